// File: rtl/ptr_pkg.sv
// Shared definitions for the SDH/SONET pointer interpreter.
// Holds the per-channel state encoding, the NDF codes, the largest legal
// pointer value for each container type, and the classifier result struct.
package ptr_pkg;

  typedef enum logic [1:0] {
    ST_NORM = 2'b00,
    ST_AIS  = 2'b01,
    ST_LOP  = 2'b10
  } ptr_st_t;

  localparam logic [3:0] NDF_NORM = 4'b0110;
  localparam logic [3:0] NDF_EN   = 4'b1001;

  localparam int MAXOFF_AU   = 782;  // AU-4 / AU-3
  localparam int MAXOFF_TU3  = 764;
  localparam int MAXOFF_TU12 = 139;
  localparam int MAXOFF_TU11 = 103;

  // I bits sit on the odd offset positions, D bits on the even ones.
  localparam logic [9:0] I_MASK = 10'h2AA;
  localparam logic [9:0] D_MASK = 10'h155;

  // One frame's classification. The classes are mutually exclusive except
  // vptr, which marks any in-range pointer with a normal NDF regardless of
  // how it compares to the active offset.
  typedef struct packed {
    logic ndf_en;
    logic ais;
    logic inc;
    logic dec;
    logic newp;
    logic inv;
    logic vptr;
  } ptr_cls_t;

  function automatic logic ham_le1(input logic [3:0] a, input logic [3:0] b);
    return $countones(a ^ b) <= 1;
  endfunction

endpackage

// File: rtl/ptr_cls.sv
// Combinational pointer classifier.
// Decodes one H1/H2 pair against the channel's active offset and cnt3
// lockout and reports which class the frame falls into.
//   h1, h2      : pointer bytes
//   act_offset  : channel's current active offset
//   cnt3        : channel's post-adjustment lockout counter
//   offset      : decoded 10-bit pointer value
//   cls         : class flags (see ptr_cls_t)
module ptr_cls
  import ptr_pkg::*;
#(
  parameter int MAXOFFSET = 782
) (
  input  logic [7:0] h1,
  input  logic [7:0] h2,
  input  logic [9:0] act_offset,
  input  logic [1:0] cnt3,
  output logic [9:0] offset,
  output ptr_cls_t   cls
);

  logic [3:0] ndf;
  logic       ndf_nrm, in_rng, norm, vote_inc, vote_dec;
  logic [9:0] flip;
  logic [2:0] i_cnt, d_cnt;

  always_comb begin
    ndf      = h1[7:4];
    offset   = {h1[1:0], h2};
    ndf_nrm  = ham_le1(ndf, NDF_NORM);
    in_rng   = offset <= 10'(MAXOFFSET);
    flip     = offset ^ act_offset;
    i_cnt    = 3'($countones(flip & I_MASK));
    d_cnt    = 3'($countones(flip & D_MASK));
    // Majority vote; range is deliberately not checked since an inverted
    // field need not be a legal pointer.
    vote_inc = ndf_nrm && (i_cnt >= 3'd3) && (d_cnt <= 3'd2);
    vote_dec = ndf_nrm && (d_cnt >= 3'd3) && (i_cnt <= 3'd2);
    norm     = ndf_nrm && in_rng && (flip == 10'd0);

    cls        = '0;
    cls.ais    = ({h1, h2} == 16'hFFFF);
    cls.ndf_en = ham_le1(ndf, NDF_EN) && in_rng;
    cls.vptr   = ndf_nrm && in_rng;
    cls.inc    = vote_inc && (cnt3 == 2'd0);
    cls.dec    = vote_dec && (cnt3 == 2'd0);
    // A vote blocked by cnt3 is neither an adjustment nor a new pointer.
    cls.newp   = ndf_nrm && in_rng && (flip != 10'd0) && !vote_inc && !vote_dec;
    cls.inv    = !(norm || cls.ndf_en || cls.ais || cls.inc || cls.dec || cls.newp);
  end

endmodule

// File: rtl/ptrint_mc.sv
// Multi-channel (time-multiplexed) AU/TU pointer interpreter.
// Each ptr_vld strobe does a full read-modify-write of the strobed channel's
// state and produces a registered result one cycle later.
//   clk19, rst        : clock, synchronous active-high reset
//   h1, h2, ch        : pointer bytes and their channel, qualified by ptr_vld
//   ptr_out, out_ch   : active offset and channel of the latest result
//   out_vld           : result strobe; inc/dec/ndf_evt are qualified by it
//   lop, ais          : per-channel loss-of-pointer / AIS state
module ptrint_mc
  import ptr_pkg::*;
#(
  parameter int NCH       = 1,
  parameter int CHW       = 1,
  parameter int MAXOFFSET = 782,
  parameter int NLOP      = 8,
  parameter int NNDF      = 8
) (
  input  logic           clk19,
  input  logic           rst,
  input  logic [7:0]     h1,
  input  logic [7:0]     h2,
  input  logic [CHW-1:0] ch,
  input  logic           ptr_vld,
  output logic [9:0]     ptr_out,
  output logic [CHW-1:0] out_ch,
  output logic           out_vld,
  output logic           inc,
  output logic           dec,
  output logic           ndf_evt,
  output logic [NCH-1:0] lop,
  output logic [NCH-1:0] ais
);

  // Arrays span the full ch range so every index is in bounds; slots at or
  // above NCH are never written and stay at their reset constants.
  localparam int         NSLOT = 2 ** CHW;
  localparam int         IW    = $clog2(NLOP + 1);
  localparam int         NW    = $clog2(NNDF + 1);
  localparam logic [9:0] MAXO  = 10'(MAXOFFSET);

  ptr_st_t       st_q     [NSLOT];
  logic [9:0]    act_q    [NSLOT];
  logic [9:0]    cand_q   [NSLOT];
  logic [1:0]    cntnew_q [NSLOT];
  logic [1:0]    cntais_q [NSLOT];
  logic [1:0]    cnt3_q   [NSLOT];
  logic [IW-1:0] cntinv_q [NSLOT];
  logic [NW-1:0] cntndf_q [NSLOT];

  ptr_st_t       st_c, st_d;
  logic [9:0]    act_c, act_d, cand_c, cand_d, offset;
  logic [1:0]    cntnew_c, cntnew_d, cntais_c, cntais_d, cnt3_c, cnt3_d;
  logic [IW-1:0] cntinv_c, cntinv_d;
  logic [NW-1:0] cntndf_c, cntndf_d;
  logic          inc_d, dec_d, ndf_d, trk, ch_ok;
  ptr_cls_t      cls;

  assign ch_ok = ({1'b0, ch} < (CHW + 1)'(NCH));

  always_comb begin
    st_c     = st_q[ch];
    act_c    = act_q[ch];
    cand_c   = cand_q[ch];
    cntnew_c = cntnew_q[ch];
    cntais_c = cntais_q[ch];
    cnt3_c   = cnt3_q[ch];
    cntinv_c = cntinv_q[ch];
    cntndf_c = cntndf_q[ch];
  end

  ptr_cls #(.MAXOFFSET(MAXOFFSET)) u_cls (
    .h1         (h1),
    .h2         (h2),
    .act_offset (act_c),
    .cnt3       (cnt3_c),
    .offset     (offset),
    .cls        (cls)
  );

  always_comb begin
    st_d     = st_c;
    act_d    = act_c;
    cand_d   = cand_c;
    cntnew_d = 2'd0;
    cntais_d = 2'd0;
    cntinv_d = '0;
    cntndf_d = '0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    ndf_d    = 1'b0;
    // Lockout runs 1,2,3 then idles at 0.
    cnt3_d   = (cnt3_c == 2'd0) ? 2'd0 : cnt3_c + 2'd1;

    // Consecutive counts: a frame of any other class leaves them at 0.
    if (cls.ais)
      cntais_d = (cntais_c == 2'd3) ? cntais_c : cntais_c + 2'd1;
    if (cls.inv)
      cntinv_d = (cntinv_c >= IW'(NLOP)) ? cntinv_c : cntinv_c + IW'(1);
    if (cls.ndf_en)
      cntndf_d = (cntndf_c >= NW'(NNDF)) ? cntndf_c : cntndf_c + NW'(1);

    // In NORM only genuine new pointers build a candidate; outside NORM any
    // valid pointer does, since the stale act_offset must not steer it.
    trk = (st_c == ST_NORM) ? cls.newp : cls.vptr;
    if (trk) begin
      cand_d   = offset;
      cntnew_d = ((cntnew_c != 2'd0) && (cand_c == offset)) ? cntnew_c + 2'd1 : 2'd1;
    end

    unique case (st_c)
      ST_NORM: begin
        if (cls.ndf_en) begin
          if (cntndf_d >= NW'(NNDF)) st_d = ST_LOP;
          else begin
            act_d  = offset;
            cnt3_d = 2'd1;
            ndf_d  = 1'b1;
          end
        end else if (cls.inc) begin
          act_d  = (act_c == MAXO) ? 10'd0 : act_c + 10'd1;
          cnt3_d = 2'd1;
          inc_d  = 1'b1;
        end else if (cls.dec) begin
          act_d  = (act_c == 10'd0) ? MAXO : act_c - 10'd1;
          cnt3_d = 2'd1;
          dec_d  = 1'b1;
        end else if (cls.newp && (cntnew_d == 2'd3)) begin
          act_d    = offset;
          cntnew_d = 2'd0;
        end else if (cls.ais && (cntais_d == 2'd3)) begin
          st_d = ST_AIS;
        end else if (cls.inv && (cntinv_d >= IW'(NLOP))) begin
          st_d = ST_LOP;
        end
      end
      ST_AIS: begin
        if (cls.ndf_en) begin
          st_d  = ST_NORM;
          act_d = offset;
          ndf_d = 1'b1;
        end else if (cls.vptr && (cntnew_d == 2'd3)) begin
          st_d  = ST_NORM;
          act_d = offset;
        end else if (cls.inv && (cntinv_d >= IW'(NLOP))) begin
          st_d = ST_LOP;
        end
      end
      default: begin
        if (cls.vptr && (cntnew_d == 2'd3)) begin
          st_d  = ST_NORM;
          act_d = offset;
        end else if (cls.ais && (cntais_d == 2'd3)) begin
          st_d = ST_AIS;
        end
      end
    endcase

    // Every state is entered with fresh counts.
    if (st_d != st_c) begin
      cntnew_d = 2'd0;
      cntais_d = 2'd0;
      cntinv_d = '0;
      cntndf_d = '0;
    end
  end

  always_ff @(posedge clk19) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]     <= ST_LOP;
        act_q[i]    <= '0;
        cand_q[i]   <= '0;
        cntnew_q[i] <= '0;
        cntais_q[i] <= '0;
        cnt3_q[i]   <= '0;
        cntinv_q[i] <= '0;
        cntndf_q[i] <= '0;
      end
      ptr_out <= '0;
      out_ch  <= '0;
      out_vld <= 1'b0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      ndf_evt <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      ndf_evt <= 1'b0;
      if (ptr_vld && ch_ok) begin
        st_q[ch]     <= st_d;
        act_q[ch]    <= act_d;
        cand_q[ch]   <= cand_d;
        cntnew_q[ch] <= cntnew_d;
        cntais_q[ch] <= cntais_d;
        cnt3_q[ch]   <= cnt3_d;
        cntinv_q[ch] <= cntinv_d;
        cntndf_q[ch] <= cntndf_d;
        ptr_out      <= act_d;
        out_ch       <= ch;
        out_vld      <= 1'b1;
        inc          <= inc_d;
        dec          <= dec_d;
        ndf_evt      <= ndf_d;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_flag
    assign lop[g] = (st_q[g] == ST_LOP);
    assign ais[g] = (st_q[g] == ST_AIS);
  end

endmodule
